svnet_skid_buffer: RTL and testbench

SVNET_SKID_BUFFER -- requirements
Module: svnet_skid_buffer

---
 rtl/svnet_skid_buffer.sv | 87 ++++++++
 tb/tb_svnet_skid_buffer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/svnet_skid_buffer.sv
// Two-entry skid buffer: registered in_ready, out_valid and out_data, so no
// combinational path crosses the block in either direction.
module svnet_skid_buffer #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       level
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] HALF  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             in_fire, out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = HALF;
                    main_d  = in_data;
                end
            end
            HALF: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low in FULL, so only a drain can happen here
                if (out_fire) begin
                    state_d = HALF;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= INIT;
            skid_q      <= INIT;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;
    assign level     = state_q;

endmodule

// File: tb/tb_svnet_skid_buffer.sv
// Skid buffer bench: directed cases plus a random valid/ready soak, all
// checked against a FIFO scoreboard sampled on the falling edge.
module tb_svnet_skid_buffer;

    localparam int         W    = 8;
    localparam logic [7:0] INIT = 8'h5A;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [1:0]   level;

    int errors = 0;
    int checks = 0;
    int n_in = 0;
    int n_out = 0;
    logic [W-1:0] sb[$];
    logic rdy_armed;

    svnet_skid_buffer #(.WIDTH(W), .INIT(INIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .level(level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // in_ready is expected low until the first edge after reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_armed <= 1'b0;
        else        rdy_armed <= 1'b1;
    end

    // Scoreboard: front of queue must be presented whenever out_valid is up,
    // which also covers data stability during stalls.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("level", 32'(level), 32'(sb.size()));
            chk("in_ready", 32'(in_ready), rdy_armed ? 32'(sb.size() != 2) : 32'd0);
            chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) chk("out_data", 32'(out_data), 32'(sb[0]));
            if (out_valid && out_ready && sb.size() != 0) begin
                void'(sb.pop_front());
                n_out++;
            end
            if (in_valid && in_ready) begin
                sb.push_back(in_data);
                n_in++;
            end
        end
    end

    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        cyc();
    endtask

    initial begin
        int cycles;
        // Reset state
        cyc(); cyc();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'(INIT));

        // First beat latency
        rst_n = 1'b1; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
        cyc();
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        chk("t1_out_valid0", 32'(out_valid), 32'd0);
        cyc();
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'hA5);
        in_valid = 1'b0;
        cyc();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // Back-to-back streaming
        for (int i = 1; i <= 16; i++) begin
            push(8'(i));
            chk("t2_level", 32'(level), 32'd1);
            chk("t2_data", 32'(out_data), 32'(i));
        end
        in_valid = 1'b0;
        cyc();

        // Stall fills the skid, ignored beat while full, then drain
        out_ready = 1'b0;
        push(8'h11);
        push(8'h22);
        chk("t3_level2", 32'(level), 32'd2);
        chk("t3_in_ready0", 32'(in_ready), 32'd0);
        chk("t3_hold", 32'(out_data), 32'h11);
        push(8'h33);
        chk("t3_still_full", 32'(level), 32'd2);
        chk("t3_hold2", 32'(out_data), 32'h11);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        chk("t3_second", 32'(out_data), 32'h22);
        chk("t3_ready_back", 32'(in_ready), 32'd1);
        cyc();
        chk("t3_empty", 32'(level), 32'd0);

        // Simultaneous in/out fire in HALF
        out_ready = 1'b0;
        push(8'h44);
        out_ready = 1'b1;
        push(8'h55);
        chk("t4_level", 32'(level), 32'd1);
        chk("t4_data", 32'(out_data), 32'h55);
        in_valid = 1'b0;
        cyc();

        // Reset while full discards both beats
        out_ready = 1'b0;
        push(8'h66);
        push(8'h77);
        in_valid = 1'b0;
        chk("t5_full", 32'(level), 32'd2);
        #2 rst_n = 1'b0;
        sb.delete();
        #1;
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd0);
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_out_data", 32'(out_data), 32'(INIT));
        cyc();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t5_no_ghost", 32'(out_valid), 32'd0);
        end

        // Random soak
        n_in = 0; n_out = 0; cycles = 0;
        while (n_in < 10000 && cycles < 40000) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = 8'($urandom);
            out_ready = ($urandom_range(2) != 0);
            cyc();
            cycles++;
        end
        chk("soak_budget", 32'(n_in >= 10000), 32'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        cyc(); cyc(); cyc();
        chk("soak_drain", 32'(sb.size()), 32'd0);
        chk("soak_count", 32'(n_out), 32'(n_in));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
